oam_dma_ctrl: RTL

- Sprite OAM DMA engine and CPU-RAM port arbiter.
- Sits between the 6502 core bus and the 2 KB cpu_ram. It also drives the PPU OAM data write strobe.
- A CPU write to $4014 halts the CPU, takes ownership of the RAM port, and copies 256 bytes from page $XX00–$XXFF to OAM. Reads come from RAM for pages $00–$1F (mirrored) or from the external bus otherwise.
- Outside DMA the CPU passes straight through to the RAM.

---
 rtl/nes_bus_pkg.sv | 21 ++
 rtl/oam_dma_ctrl_mux.sv | 27 ++
 rtl/oam_dma_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: DMA state encoding and address-map constants.
// Imported by the OAM DMA controller and its RAM port mux.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } dma_state_t;

   localparam logic [15:0] ADDR_OAMDMA    = 16'h4014;
   localparam logic [15:0] RAM_MIRROR_TOP = 16'h2000;

   // Pages below the mirror top live in the 2 KB cpu_ram; everything else is external.
   function automatic logic page_is_ram(input logic [7:0] page);
      return ({page, 8'h00} < RAM_MIRROR_TOP);
   endfunction

endpackage

// File: rtl/oam_dma_ctrl_mux.sv
// Combinational cpu_ram port select: the CPU owns the port in IDLE, the DMA engine otherwise.
// While DMA owns the port the RAM is only ever read.
module cpu_ram_mux #(
   parameter int RAM_AW = 11
) (
   input  logic              dma_busy,
   input  logic [RAM_AW-1:0] cpu_ram_addr,
   input  logic              cpu_ram_we,
   input  logic [7:0]        cpu_ram_wdata,
   input  logic [RAM_AW-1:0] dma_ram_addr,
   output logic [RAM_AW-1:0] ram_address,
   output logic              ram_write_enable,
   output logic [7:0]        ram_write_data
);

   always_comb begin
      ram_address      = cpu_ram_addr;
      ram_write_enable = cpu_ram_we;
      ram_write_data   = cpu_ram_wdata;
      if (dma_busy) begin
         ram_address      = dma_ram_addr;
         ram_write_enable = 1'b0;
         ram_write_data   = 8'h00;
      end
   end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine: a $4014 write halts the CPU and copies one page to PPU OAMDATA,
// reading from cpu_ram (pages $00-$1F, mirrored) or the external bus; otherwise CPU passes through.
module oam_dma_ctrl
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = ADDR_OAMDMA,
   parameter int          RAM_AW       = 11,
   parameter int          XFER_LEN     = 256
) (
   input  logic              clk,
   input  logic              reset,
   // Bus protocol: cpu_valid qualifies a CPU cycle and is sampled on every clk edge;
   // there is no ready - cpu_halt is the only backpressure and the CPU must hold off while it is high.
   input  logic              cpu_valid,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_write,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_halt,
   output logic [RAM_AW-1:0] ram_address,
   output logic              ram_write_enable,
   output logic [7:0]        ram_write_data,
   input  logic [7:0]        ram_read_data,
   output logic              ext_rd,
   output logic [15:0]       ext_addr,
   input  logic [7:0]        ext_rdata,
   output logic              oam_wr,
   output logic [7:0]        oam_wdata,
   output logic              dma_busy,
   output dma_state_t        dbg_state
);

   localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

   dma_state_t  state_q, state_d;
   logic [7:0]  page_q;
   logic [7:0]  idx_q;
   logic        cycle_odd_q;
   logic        trigger;
   logic        idx_last;
   logic        src_ram;
   logic        cpu_ram_we;
   logic [RAM_AW-1:0] dma_ram_addr;

   assign trigger  = (state_q == IDLE) && cpu_valid && cpu_write && (cpu_addr == DMA_REG_ADDR);
   assign idx_last = (idx_q == IDX_LAST);
   assign src_ram  = page_is_ram(page_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         page_q      <= 8'h00;
         idx_q       <= 8'h00;
         cycle_odd_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cycle_odd_q <= ~cycle_odd_q;
         if (trigger) begin
            page_q <= cpu_wdata;
         end
         if (state_q == WRITE) begin
            idx_q <= idx_last ? 8'h00 : idx_q + 8'd1;
         end
      end
   end

   // HALT burns one cycle; ALIGN is inserted when needed so every READ lands on an even (get) cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trigger) state_d = HALT;
         HALT:    state_d = cycle_odd_q ? READ : ALIGN;
         ALIGN:   state_d = READ;
         READ:    state_d = WRITE;
         WRITE:   state_d = idx_last ? IDLE : READ;
         default: state_d = IDLE;
      endcase
   end

   assign cpu_halt  = (state_q != IDLE);
   assign dma_busy  = (state_q != IDLE);
   assign dbg_state = state_q;
   assign cpu_rdata = ram_read_data;

   assign ext_rd    = (state_q == READ) && !src_ram;
   assign ext_addr  = {page_q, idx_q};
   assign oam_wr    = (state_q == WRITE);
   assign oam_wdata = src_ram ? ram_read_data : ext_rdata;

   // Truncating {page, idx} to the RAM width yields the mirrored address {page[2:0], idx}.
   assign dma_ram_addr = RAM_AW'({page_q, idx_q});
   assign cpu_ram_we   = cpu_valid && cpu_write && (cpu_addr[15:13] == 3'b000) && !trigger;

   cpu_ram_mux #(
      .RAM_AW(RAM_AW)
   ) u_mux (
      .dma_busy         (dma_busy),
      .cpu_ram_addr     (cpu_addr[RAM_AW-1:0]),
      .cpu_ram_we       (cpu_ram_we),
      .cpu_ram_wdata    (cpu_wdata),
      .dma_ram_addr     (dma_ram_addr),
      .ram_address      (ram_address),
      .ram_write_enable (ram_write_enable),
      .ram_write_data   (ram_write_data)
   );

endmodule
